// File: rtl/blit_pkg.sv
// ---------------------------------------------------------------------------
// blit_pkg
// Shared definitions for the sprite blitter: the controller state encoding,
// the default sprite/framebuffer geometry and the default transparent
// palette index. Imported by blit_scan_counter and sprite_blitter.
// ---------------------------------------------------------------------------
package blit_pkg;

  // Controller states: wait for a request, stream ROM addresses, let the
  // two-deep pipeline empty, then announce completion.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } blit_state_t;

  // Default geometry: 32x32 sprites drawn into a 160x120 framebuffer.
  localparam int SPRITE_W_DEF = 32;
  localparam int SPRITE_H_DEF = 32;
  localparam int FB_W_DEF     = 160;
  localparam int FB_H_DEF     = 120;
  localparam int ROM_AW_DEF   = 12;
  localparam int FB_AW_DEF    = 15;

  // Palette index that marks a see-through sprite pixel.
  localparam logic [3:0] TRANSPARENT_DEF = 4'h0;

endpackage

// File: rtl/blit_scan_counter.sv
// ---------------------------------------------------------------------------
// blit_scan_counter
// Row-major pixel counter for one sprite. Holds the (row, col) of the pixel
// whose ROM address is currently presented, produces the column actually
// read from the ROM (mirrored when requested) and flags the final pixel.
//
// Ports:
//   i_clk     clock
//   i_rstN    asynchronous active-low reset
//   i_clear   restart the scan at pixel (0,0)
//   i_advance step to the next pixel in row-major order
//   i_mirror  1 = read columns right-to-left
//   o_row     current sprite row
//   o_col     current destination column (never mirrored)
//   o_colRd   column used for the ROM address
//   o_last    current pixel is the bottom-right one
// ---------------------------------------------------------------------------
module blit_scan_counter
  import blit_pkg::*;
#(
  parameter int SPRITE_W = SPRITE_W_DEF,
  parameter int SPRITE_H = SPRITE_H_DEF,
  localparam int COL_W = $clog2(SPRITE_W),
  localparam int ROW_W = $clog2(SPRITE_H)
) (
  input  logic             i_clk,
  input  logic             i_rstN,
  input  logic             i_clear,
  input  logic             i_advance,
  input  logic             i_mirror,
  output logic [ROW_W-1:0] o_row,
  output logic [COL_W-1:0] o_col,
  output logic [COL_W-1:0] o_colRd,
  output logic             o_last
);

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(SPRITE_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(SPRITE_H - 1);

  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;

  // Column wraps into the next row; the controller stops advancing on the
  // last pixel, so the row never needs its own wrap.
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_clear) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_advance) begin
      if (r_col == COL_MAX) begin
        r_col <= '0;
        r_row <= r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  assign o_row   = r_row;
  assign o_col   = r_col;
  // Mirroring only changes which ROM column is fetched; the destination
  // column still runs left-to-right.
  assign o_colRd = i_mirror ? (COL_MAX - r_col) : r_col;
  assign o_last  = (r_row == ROW_MAX) && (r_col == COL_MAX);

endmodule

// File: rtl/sprite_blitter.sv
// ---------------------------------------------------------------------------
// sprite_blitter
// Copies one 4-bit indexed sprite from a synchronous ROM into the
// framebuffer at (pos_x, pos_y), optionally mirrored horizontally.
// Transparent and off-screen pixels are skipped without changing timing:
// every blit streams all SPRITE_W*SPRITE_H pixels, one per clock.
//
// Ports:
//   vga_clk      clock
//   reset_n      asynchronous active-low reset
//   start        blit request, only looked at while idle
//   pos_x/pos_y  destination of the sprite's top-left corner
//   sprite_base  ROM address of sprite pixel (0,0)
//   mirror_x     1 = read sprite columns right-to-left
//   rom_addr     address to the sprite ROM
//   rom_q        ROM data, one clock after rom_addr is sampled
//   fb_we        framebuffer write strobe
//   fb_addr      framebuffer write address (y*FB_W + x)
//   fb_data      palette index written
//   busy         blit in progress
//   done         one-cycle completion pulse
// ---------------------------------------------------------------------------
module sprite_blitter
  import blit_pkg::*;
#(
  parameter int         SPRITE_W    = SPRITE_W_DEF,
  parameter int         SPRITE_H    = SPRITE_H_DEF,
  parameter int         FB_W        = FB_W_DEF,
  parameter int         FB_H        = FB_H_DEF,
  parameter int         ROM_AW      = ROM_AW_DEF,
  parameter int         FB_AW       = FB_AW_DEF,
  parameter logic [3:0] TRANSPARENT = TRANSPARENT_DEF
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic [ROM_AW-1:0] sprite_base,
  input  logic              mirror_x,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [3:0]        rom_q,
  output logic              fb_we,
  output logic [FB_AW-1:0]  fb_addr,
  output logic [3:0]        fb_data,
  output logic              busy,
  output logic              done
);

  localparam int COL_W = $clog2(SPRITE_W);
  localparam int ROW_W = $clog2(SPRITE_H);

  blit_state_t       r_state;
  blit_state_t       w_nextState;
  logic              r_drainHalf;
  logic              w_accept;
  logic              w_advance;

  logic [9:0]        r_posX;
  logic [9:0]        r_posY;
  logic [ROM_AW-1:0] r_base;
  logic              r_mirror;

  logic [ROW_W-1:0]  w_row;
  logic [COL_W-1:0]  w_col;
  logic [COL_W-1:0]  w_colRd;
  logic              w_last;

  logic [10:0]       w_dstX;
  logic [10:0]       w_dstY;
  logic              r_s1Valid;
  logic [10:0]       r_s1X;
  logic [10:0]       r_s1Y;
  logic              w_visible;
  logic [FB_AW-1:0]  w_fbLin;

  // State register plus the flag that separates the two drain cycles.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_drainHalf <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_drainHalf <= (r_state == DRAIN) && !r_drainHalf;
    end
  end

  // Next-state and control decode. DRAIN lasts two cycles so the last
  // pixel leaves the address/data pipeline before done is raised.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_advance   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_nextState = READ;
        end
      end
      READ: begin
        busy = 1'b1;
        if (w_last) begin
          w_nextState = DRAIN;
        end else begin
          w_advance = 1'b1;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (r_drainHalf) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        done        = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Request parameters are captured once so the caller may change the
  // inputs while the blit runs.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_posX   <= '0;
      r_posY   <= '0;
      r_base   <= '0;
      r_mirror <= 1'b0;
    end else if (w_accept) begin
      r_posX   <= pos_x;
      r_posY   <= pos_y;
      r_base   <= sprite_base;
      r_mirror <= mirror_x;
    end
  end

  blit_scan_counter #(
    .SPRITE_W (SPRITE_W),
    .SPRITE_H (SPRITE_H)
  ) u_scan (
    .i_clk     (vga_clk),
    .i_rstN    (reset_n),
    .i_clear   (w_accept),
    .i_advance (w_advance),
    .i_mirror  (r_mirror),
    .o_row     (w_row),
    .o_col     (w_col),
    .o_colRd   (w_colRd),
    .o_last    (w_last)
  );

  // ROM address wraps at ROM_AW bits so sprites may straddle the top.
  assign rom_addr = r_base
                  + ROM_AW'(w_row) * ROM_AW'(SPRITE_W)
                  + ROM_AW'(w_colRd);

  // Destination computed one bit wider than the position so a sprite
  // hanging off the right/bottom edge clips instead of wrapping.
  assign w_dstX = {1'b0, r_posX} + 11'(w_col);
  assign w_dstY = {1'b0, r_posY} + 11'(w_row);

  // First pipeline stage travels alongside the ROM read latency.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1Valid <= 1'b0;
      r_s1X     <= '0;
      r_s1Y     <= '0;
    end else begin
      r_s1Valid <= (r_state == READ);
      r_s1X     <= w_dstX;
      r_s1Y     <= w_dstY;
    end
  end

  assign w_visible = r_s1Valid
                  && (rom_q != TRANSPARENT)
                  && (r_s1X < 11'(FB_W))
                  && (r_s1Y < 11'(FB_H));

  // Only evaluated for on-screen pixels, whose linear address fits FB_AW.
  assign w_fbLin = FB_AW'(r_s1Y) * FB_AW'(FB_W) + FB_AW'(r_s1X);

  // Framebuffer write stage; address and data hold between writes.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      fb_we   <= 1'b0;
      fb_addr <= '0;
      fb_data <= '0;
    end else begin
      fb_we <= w_visible;
      if (w_visible) begin
        fb_addr <= w_fbLin;
        fb_data <= rom_q;
      end
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// ---------------------------------------------------------------------------
// tb_sprite_blitter
// Self-checking bench for sprite_blitter. A synchronous ROM model feeds the
// DUT; every framebuffer write is collected and compared with a reference
// list built by walking the sprite pixel by pixel.
// ---------------------------------------------------------------------------
module tb_sprite_blitter;

  localparam int N   = 1024;
  localparam int FBW = 160;
  localparam int FBH = 120;

  logic        vga_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  pos_x = '0;
  logic [9:0]  pos_y = '0;
  logic [11:0] sprite_base = '0;
  logic        mirror_x = 1'b0;
  logic [11:0] rom_addr;
  logic [3:0]  rom_q = '0;
  logic        fb_we;
  logic [14:0] fb_addr;
  logic [3:0]  fb_data;
  logic        busy;
  logic        done;

  sprite_blitter dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .start       (start),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .sprite_base (sprite_base),
    .mirror_x    (mirror_x),
    .rom_addr    (rom_addr),
    .rom_q       (rom_q),
    .fb_we       (fb_we),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data),
    .busy        (busy),
    .done        (done)
  );

  always #5 vga_clk = ~vga_clk;

  int cyc = 0;
  always @(posedge vga_clk) cyc++;

  // Synchronous sprite ROM.
  logic [3:0] rom [0:4095];
  always @(posedge vga_clk) rom_q <= rom[rom_addr];

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t gotQ[$];
  wr_t expQ[$];
  int  weSeen = 0;
  int  doneSeen = 0;

  // Write/done monitor, sampled on the falling edge.
  always @(negedge vga_clk) begin
    wr_t w;
    if (fb_we === 1'b1) begin
      w.addr = int'(fb_addr);
      w.data = int'(fb_data);
      gotQ.push_back(w);
      weSeen++;
    end
    if (done === 1'b1) doneSeen++;
  end

  int checks = 0;
  int failures = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // ROM fill patterns: 0 = (addr mod 15)+1, 1 = same with even addresses
  // transparent, 2 = random indices.
  task automatic fillRom(input int pat);
    for (int a = 0; a < 4096; a++) begin
      case (pat)
        0:       rom[a] = 4'((a % 15) + 1);
        1:       rom[a] = (a % 2 == 0) ? 4'd0 : 4'((a % 15) + 1);
        default: rom[a] = 4'($urandom_range(0, 15));
      endcase
    end
  endtask

  // Reference: visit every sprite pixel in row-major order and keep the
  // ones that are opaque and land inside the framebuffer.
  task automatic buildModel(input int px, input int py, input int base, input int mir);
    for (int r = 0; r < 32; r++) begin
      for (int c = 0; c < 32; c++) begin
        int  srcCol;
        int  a;
        int  x;
        int  y;
        wr_t w;
        srcCol = (mir != 0) ? (31 - c) : c;
        a = (base + r * 32 + srcCol) % 4096;
        x = px + c;
        y = py + r;
        if (rom[a] != 4'd0 && x < FBW && y < FBH) begin
          w.addr = y * FBW + x;
          w.data = int'(rom[a]);
          expQ.push_back(w);
        end
      end
    end
  endtask

  function automatic int firstDiff();
    int n;
    n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
    for (int i = 0; i < n; i++) begin
      if (gotQ[i].addr != expQ[i].addr || gotQ[i].data != expQ[i].data) return i;
    end
    if (gotQ.size() != expQ.size()) return n;
    return -1;
  endfunction

  task automatic compareWrites(input string name);
    int d;
    d = firstDiff();
    checks++;
    if (d != -1) begin
      failures++;
      $display("[TB] FAIL %s writes: got %0d writes, expected %0d, first difference at write %0d",
               name, gotQ.size(), expQ.size(), d);
    end
  endtask

  function automatic int probeData(input int a);
    int d;
    d = -1;
    foreach (gotQ[i]) if (gotQ[i].addr == a) d = gotQ[i].data;
    return d;
  endfunction

  // Issue one blit and watch busy/done every cycle until done has passed.
  task automatic runBlit(input int px, input int py, input int base, input int mir,
                         output int doneK, output int timingErr);
    int e;
    doneK = -1;
    timingErr = 0;
    @(negedge vga_clk);
    pos_x       = 10'(px);
    pos_y       = 10'(py);
    sprite_base = 12'(base);
    mirror_x    = (mir != 0);
    start       = 1'b1;
    e = cyc + 1;
    for (int k = 0; k <= N + 3; k++) begin
      @(negedge vga_clk);
      if (k == 0) begin
        start       = 1'b0;
        pos_x       = 10'($urandom);
        pos_y       = 10'($urandom);
        sprite_base = 12'($urandom);
        mirror_x    = ~mirror_x;
      end
      if (busy !== ((cyc - e) <= N + 1)) timingErr++;
      if (done !== ((cyc - e) == N + 2)) timingErr++;
      if (done === 1'b1 && doneK < 0) doneK = cyc - e;
    end
  endtask

  typedef struct {
    int px;
    int py;
    int base;
    int mir;
    int pat;
    int expCount;
    int probeAddr;
    int probeData;
    int lastAddr;
  } vec_t;

  task automatic applyStimulus(input int idx, input vec_t v);
    int doneK;
    int terr;
    fillRom(v.pat);
    expQ.delete();
    buildModel(v.px, v.py, v.base, v.mir);
    gotQ.delete();
    runBlit(v.px, v.py, v.base, v.mir, doneK, terr);
    checkOutput($sformatf("v%0d writeCount", idx), gotQ.size(), v.expCount);
    compareWrites($sformatf("v%0d", idx));
    checkOutput($sformatf("v%0d doneLatency", idx), doneK, N + 2);
    checkOutput($sformatf("v%0d busyDoneTiming", idx), terr, 0);
    if (v.probeAddr >= 0)
      checkOutput($sformatf("v%0d probe@%0d", idx, v.probeAddr), probeData(v.probeAddr), v.probeData);
    if (v.lastAddr >= 0)
      checkOutput($sformatf("v%0d lastAddr", idx),
                  (gotQ.size() > 0) ? gotQ[gotQ.size()-1].addr : -1, v.lastAddr);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[11];
    int   doneK;
    int   terr;
    int   doneKs[$];
    int   e;

    //          px    py   base mir pat cnt   probeA pD  lastAddr
    vecs[0]  = '{0,    0,   0,   0,  0, 1024, 161,   4,  -1};
    vecs[1]  = '{0,    0,   0,   1,  0, 1024, 0,     2,  -1};
    vecs[2]  = '{0,    0,   0,   1,  0, 1024, 160,   4,  -1};
    vecs[3]  = '{0,    0,   0,   0,  1, 512,  161,   4,  4991};
    vecs[4]  = '{150,  110, 0,   0,  0, 100,  -1,    -1, 19199};
    vecs[5]  = '{128,  88,  0,   0,  0, 1024, -1,    -1, 19199};
    vecs[6]  = '{160,  0,   0,   0,  0, 0,    -1,    -1, -1};
    vecs[7]  = '{1000, 1000,0,   0,  0, 0,    -1,    -1, -1};
    vecs[8]  = '{140,  100, 64,  1,  1, 200,  -1,    -1, 19198};
    vecs[9]  = '{10,   20,  4090,0,  0, 1024, 3216,  1,  -1};
    vecs[10] = '{0,    119, 0,   0,  0, 32,   -1,    -1, 19071};

    fillRom(0);

    // Outputs while reset is held.
    #12;
    checkOutput("reset fb_we", int'(fb_we), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset rom_addr", int'(rom_addr), 0);
    checkOutput("reset fb_addr", int'(fb_addr), 0);
    checkOutput("reset fb_data", int'(fb_data), 0);
    @(negedge vga_clk);
    reset_n = 1'b1;
    repeat (2) @(negedge vga_clk);

    for (int i = 0; i < 11; i++) applyStimulus(i, vecs[i]);

    // Randomised blits against the reference walk.
    for (int i = 0; i < 5; i++) begin
      vec_t rv;
      rv.px   = $urandom_range(0, 200);
      rv.py   = $urandom_range(0, 150);
      rv.base = $urandom_range(0, 4095);
      rv.mir  = $urandom_range(0, 1);
      fillRom(2);
      expQ.delete();
      buildModel(rv.px, rv.py, rv.base, rv.mir);
      gotQ.delete();
      runBlit(rv.px, rv.py, rv.base, rv.mir, doneK, terr);
      compareWrites($sformatf("rand%0d", i));
      checkOutput($sformatf("rand%0d doneLatency", i), doneK, N + 2);
      checkOutput($sformatf("rand%0d busyDoneTiming", i), terr, 0);
    end

    // Restart ignored while busy; start held through done begins a second
    // blit with the inputs present on the cycle after done.
    fillRom(0);
    expQ.delete();
    buildModel(20, 30, 0, 0);
    buildModel(5, 7, 0, 1);
    gotQ.delete();
    doneKs.delete();
    terr = 0;
    @(negedge vga_clk);
    pos_x = 10'd20; pos_y = 10'd30; sprite_base = 12'd0; mirror_x = 1'b0;
    start = 1'b1;
    e = cyc + 1;
    for (int k = 0; k <= 2 * N + 7; k++) begin
      @(negedge vga_clk);
      if (k == 0) start = 1'b0;
      if (k == 500) begin
        start = 1'b1; pos_x = 10'd5; pos_y = 10'd7; mirror_x = 1'b1;
      end
      if (busy !== ((k <= N + 1) || (k >= N + 4 && k <= 2 * N + 5))) terr++;
      if (done !== (k == N + 2 || k == 2 * N + 6)) terr++;
      if (done === 1'b1) doneKs.push_back(cyc - e);
      if (k == N + 4) start = 1'b0;
    end
    compareWrites("heldStart");
    checkOutput("heldStart busyDoneTiming", terr, 0);
    checkOutput("heldStart doneCount", doneKs.size(), 2);
    checkOutput("heldStart secondDone", (doneKs.size() == 2) ? doneKs[1] : -1, 2 * N + 6);

    // Reset in the middle of a blit.
    fillRom(0);
    @(negedge vga_clk);
    pos_x = 10'd0; pos_y = 10'd0; sprite_base = 12'd0; mirror_x = 1'b0;
    start = 1'b1;
    e = cyc + 1;
    for (int k = 0; k <= 300; k++) begin
      @(negedge vga_clk);
      if (k == 0) start = 1'b0;
    end
    #1 reset_n = 1'b0;
    #1;
    checkOutput("abort fb_we", int'(fb_we), 0);
    checkOutput("abort busy", int'(busy), 0);
    checkOutput("abort done", int'(done), 0);
    checkOutput("abort rom_addr", int'(rom_addr), 0);
    checkOutput("abort fb_addr", int'(fb_addr), 0);
    weSeen = 0;
    doneSeen = 0;
    repeat (3) @(negedge vga_clk);
    reset_n = 1'b1;
    repeat (1100) @(negedge vga_clk);
    checkOutput("abort writesAfter", weSeen, 0);
    checkOutput("abort doneAfter", doneSeen, 0);
    checkOutput("abort busyAfter", int'(busy), 0);

    applyStimulus(100, vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
